// File: rtl/alu_chkr_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_chkr_sb : protocol/result checker and scoreboard for the serial ALU.    |
// | Optional: ALU_CHKR_SB_DISPLAY_EN prints one line per verdict pulse.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu_chkr_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LAT    = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  opcode_valid,
  input  logic                  opcode,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow,
  input  logic                  done,
  input  logic [4:0]            checker_enable,
  output logic [4:0]            chk_pass,
  output logic [4:0]            chk_fail,
  output logic [4:0]            err_sticky,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  fail_cnt
);

  localparam int               LAT_W     = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(MAX_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPB  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]            op_q, op_d;
  logic [2:0]            snap_q, snap_d;
  logic [LAT_W-1:0]      lat_q, lat_d, lat_inc;
  logic [1:0]            rst_cnt_q, rst_cnt_d;
  logic                  c1_bad_q, c1_bad_d;
  logic [4:0]            pass_q, pass_d, fail_q, fail_d, sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [DATA_WIDTH:0]   exp_val;
  logic                  in_reset_seq;

  function automatic logic [2:0] ones5(input logic [4:0] v);
    ones5 = 3'd0;
    for (int i = 0; i < 5; i++) ones5 = ones5 + {2'b00, v[i]};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [2:0]           n);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + (CNT_WIDTH+1)'(n);
    sat_add = s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  // Expected value carries the carry/borrow in its top bit
  always_comb begin
    exp_val = '0;
    case (op_q)
      2'b00:   exp_val = {1'b0, a_q} + {1'b0, b_q};
      2'b01:   exp_val = {1'b0, a_q} - {1'b0, b_q};
      2'b10:   exp_val = {1'b0, a_q ^ b_q};
      default: exp_val = {1'b0, ~(a_q ^ b_q)};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    snap_d       = snap_q;
    lat_d        = lat_q;
    rst_cnt_d    = rst_cnt_q;
    c1_bad_d     = c1_bad_q;
    pass_d       = '0;
    fail_d       = '0;
    lat_inc      = lat_q + LAT_W'(1);
    in_reset_seq = (rst_cnt_q == 2'd1) || (rst_cnt_q == 2'd2);

    if (reset) begin
      // First reset edge only arms tracking; outputs are judged from the second on
      rst_cnt_d = in_reset_seq ? 2'd2 : 2'd1;
      c1_bad_d  = in_reset_seq ? c1_bad_q : 1'b0;
      if (in_reset_seq && ((result != '0) || overflow || done)) c1_bad_d = 1'b1;
    end else begin
      if (in_reset_seq) begin
        rst_cnt_d = 2'd0;
        c1_bad_d  = 1'b0;
        if (checker_enable[0]) begin
          pass_d[0] = ~c1_bad_q;
          fail_d[0] = c1_bad_q;
        end
      end

      if (opcode_valid && checker_enable[1]) begin
        if ($isunknown({opcode, data})) fail_d[1] = 1'b1;
        else                            pass_d[1] = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (done && checker_enable[2]) fail_d[2] = 1'b1;
          if (opcode_valid) begin
            a_d     = data;
            op_d[0] = opcode;
            snap_d  = checker_enable[4:2];
            state_d = S_OPB;
          end
        end
        S_OPB: begin
          if (done && snap_q[0]) fail_d[2] = 1'b1;
          if (opcode_valid) begin
            b_d     = data;
            op_d[1] = opcode;
            lat_d   = '0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (opcode_valid) begin
            // Protocol violation: abandon the op and treat this beat as a new A
            fail_d[2] = snap_q[0];
            a_d       = data;
            op_d[0]   = opcode;
            snap_d    = checker_enable[4:2];
            state_d   = S_OPB;
          end else if (done) begin
            pass_d[2] = snap_q[0];
            if (snap_q[1]) begin
              if (result == exp_val[DATA_WIDTH-1:0]) pass_d[3] = 1'b1;
              else                                   fail_d[3] = 1'b1;
            end
            if (snap_q[2]) begin
              if (overflow == exp_val[DATA_WIDTH]) pass_d[4] = 1'b1;
              else                                 fail_d[4] = 1'b1;
            end
            state_d = S_IDLE;
          end else if (lat_inc >= LAT_LIMIT) begin
            fail_d[2] = snap_q[0];
            state_d   = S_IDLE;
          end else begin
            lat_d = lat_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    sticky_d   = sticky_q | fail_d;
    pass_cnt_d = sat_add(pass_cnt_q, ones5(pass_d));
    fail_cnt_d = sat_add(fail_cnt_q, ones5(fail_d));
  end

  always_ff @(posedge clk) begin
    rst_cnt_q <= rst_cnt_d;
    c1_bad_q  <= c1_bad_d;
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      snap_q     <= '0;
      lat_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      sticky_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      snap_q     <= snap_d;
      lat_q      <= lat_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      sticky_q   <= sticky_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign chk_pass   = pass_q;
  assign chk_fail   = fail_q;
  assign err_sticky = sticky_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;

`ifdef ALU_CHKR_SB_DISPLAY_EN
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        if (pass_d[i])
          $display("CHECKER %0d PASSED t=%0t exp=%h/%b obs=%h/%b", i + 1, $time,
                   exp_val[DATA_WIDTH-1:0], exp_val[DATA_WIDTH], result, overflow);
        if (fail_d[i])
          $display("CHECKER %0d FAILED t=%0t exp=%h/%b obs=%h/%b", i + 1, $time,
                   exp_val[DATA_WIDTH-1:0], exp_val[DATA_WIDTH], result, overflow);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_chkr_sb.sv
`default_nettype none
// Directed testbench for alu_chkr_sb; small counter width so saturation is reachable.
module tb_alu_chkr_sb;

  logic       clk = 1'b0;
  logic       reset, opcode_valid, opcode, overflow, done;
  logic [7:0] data, result;
  logic [4:0] checker_enable;
  logic [4:0] chk_pass, chk_fail, err_sticky;
  logic [3:0] pass_cnt, fail_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_chkr_sb #(.DATA_WIDTH(8), .MAX_LAT(2), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .opcode_valid(opcode_valid), .opcode(opcode),
    .data(data), .result(result), .overflow(overflow), .done(done),
    .checker_enable(checker_enable), .chk_pass(chk_pass), .chk_fail(chk_fail),
    .err_sticky(err_sticky), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; opcode_valid = 1'b0; opcode = 1'b0; data = 8'h00;
    result = 8'h00; overflow = 1'b0; done = 1'b0; checker_enable = 5'h1F;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_op(input logic [7:0] a, input logic op0, input logic [7:0] b,
                        input logic op1, input int lat, input logic [7:0] res,
                        input logic ovf);
    opcode_valid = 1'b1; opcode = op0; data = a;
    tick();
    opcode = op1; data = b;
    tick();
    opcode_valid = 1'b0; opcode = 1'b0; data = 8'h00;
    repeat (lat - 1) tick();
    done = 1'b1; result = res; overflow = ovf;
    tick();
    done = 1'b0; result = 8'h00; overflow = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode_valid = 1'b0; opcode = 1'b0; data = 8'h00;
    result = 8'h00; overflow = 1'b0; done = 1'b0; checker_enable = 5'h1F;
    repeat (3) tick();
    n_checks++;
    if ({chk_pass, chk_fail, err_sticky} !== 15'h0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected 0", {chk_pass, chk_fail, err_sticky});
    end
    n_checks++;
    if ({pass_cnt, fail_cnt} !== 8'h00) begin
      n_errors++; $display("FAIL reset_counters: got %h expected 00", {pass_cnt, fail_cnt});
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (chk_pass !== 5'b00001 || chk_fail !== 5'b00000) begin
      n_errors++; $display("FAIL c1_release_pulse: got pass=%b fail=%b expected pass=00001 fail=00000", chk_pass, chk_fail);
    end
    n_checks++;
    if (pass_cnt !== 4'd1 || fail_cnt !== 4'd0) begin
      n_errors++; $display("FAIL c1_release_cnt: got pass_cnt=%0d fail_cnt=%0d expected 1 0", pass_cnt, fail_cnt);
    end
    tick();
    n_checks++;
    if (chk_pass !== 5'b00000) begin
      n_errors++; $display("FAIL c1_single_pulse: got %b expected 00000", chk_pass);
    end
  endtask

  task automatic test_reset_fail();
    reset = 1'b1; result = 8'h55;
    repeat (3) tick();
    reset = 1'b0; result = 8'h00;
    tick();
    n_checks++;
    if (chk_fail !== 5'b00001 || chk_pass !== 5'b00000) begin
      n_errors++; $display("FAIL c1_nonzero_result: got pass=%b fail=%b expected pass=00000 fail=00001", chk_pass, chk_fail);
    end
    n_checks++;
    if (err_sticky !== 5'b00001 || fail_cnt !== 4'd1) begin
      n_errors++; $display("FAIL c1_sticky_cnt: got sticky=%b fail_cnt=%0d expected 00001 1", err_sticky, fail_cnt);
    end
  endtask

  task automatic test_add();
    do_reset();
    opcode_valid = 1'b1; opcode = 1'b0; data = 8'hF0;
    tick();
    n_checks++;
    if (chk_pass !== 5'b00010) begin
      n_errors++; $display("FAIL c2_clean_operand: got %b expected 00010", chk_pass);
    end
    data = 8'h20;
    tick();
    opcode_valid = 1'b0; data = 8'h00;
    tick();
    n_checks++;
    if (chk_pass !== 5'b00000 || chk_fail !== 5'b00000) begin
      n_errors++; $display("FAIL add_wait_quiet: got pass=%b fail=%b expected 0 0", chk_pass, chk_fail);
    end
    done = 1'b1; result = 8'h10; overflow = 1'b1;
    tick();
    done = 1'b0; result = 8'h00; overflow = 1'b0;
    n_checks++;
    if (chk_pass !== 5'b11100 || chk_fail !== 5'b00000) begin
      n_errors++; $display("FAIL add_lat2_pass: got pass=%b fail=%b expected 11100 00000", chk_pass, chk_fail);
    end
    n_checks++;
    if (pass_cnt !== 4'd6) begin
      n_errors++; $display("FAIL add_pass_cnt: got %0d expected 6", pass_cnt);
    end
  endtask

  task automatic test_sub();
    run_op(8'h05, 1'b1, 8'h07, 1'b0, 1, 8'hFE, 1'b1);
    n_checks++;
    if (chk_pass !== 5'b11100 || chk_fail !== 5'b00000) begin
      n_errors++; $display("FAIL sub_pass: got pass=%b fail=%b expected 11100 00000", chk_pass, chk_fail);
    end
    run_op(8'h05, 1'b1, 8'h07, 1'b0, 1, 8'hFE, 1'b0);
    n_checks++;
    if (chk_pass !== 5'b01100 || chk_fail !== 5'b10000) begin
      n_errors++; $display("FAIL sub_bad_borrow: got pass=%b fail=%b expected 01100 10000", chk_pass, chk_fail);
    end
    n_checks++;
    if (err_sticky !== 5'b10000 || fail_cnt !== 4'd1) begin
      n_errors++; $display("FAIL sub_sticky_cnt: got sticky=%b fail_cnt=%0d expected 10000 1", err_sticky, fail_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode_valid = 1'b1; opcode = 1'b0; data = 8'h03;
    tick();
    data = 8'h04;
    tick();
    opcode_valid = 1'b0; data = 8'h00;
    tick();
    n_checks++;
    if (chk_fail !== 5'b00000 || chk_pass !== 5'b00000) begin
      n_errors++; $display("FAIL timeout_early: got pass=%b fail=%b expected 0 0", chk_pass, chk_fail);
    end
    tick();
    n_checks++;
    if (chk_fail !== 5'b00100 || chk_pass !== 5'b00000) begin
      n_errors++; $display("FAIL timeout_c3: got pass=%b fail=%b expected 00000 00100", chk_pass, chk_fail);
    end
    done = 1'b1; result = 8'h07;
    tick();
    done = 1'b0; result = 8'h00;
    n_checks++;
    if (chk_fail !== 5'b00100 || chk_pass !== 5'b00000) begin
      n_errors++; $display("FAIL timeout_back_idle: got pass=%b fail=%b expected 00000 00100", chk_pass, chk_fail);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    opcode_valid = 1'b1; opcode = 1'b0; data = 8'h40;
    tick();
    tick();
    opcode = 1'b0; data = 8'h11;
    tick();
    n_checks++;
    if (chk_fail !== 5'b00100 || chk_pass !== 5'b00010) begin
      n_errors++; $display("FAIL valid_in_wait: got pass=%b fail=%b expected 00010 00100", chk_pass, chk_fail);
    end
    opcode = 1'b1; data = 8'h22;
    tick();
    opcode_valid = 1'b0; opcode = 1'b0; data = 8'h00;
    done = 1'b1; result = 8'h33; overflow = 1'b0;
    tick();
    done = 1'b0; result = 8'h00;
    n_checks++;
    if (chk_pass !== 5'b11100 || chk_fail !== 5'b00000) begin
      n_errors++; $display("FAIL xor_after_restart: got pass=%b fail=%b expected 11100 00000", chk_pass, chk_fail);
    end
    run_op(8'h0F, 1'b1, 8'h3C, 1'b1, 2, 8'hCC, 1'b0);
    n_checks++;
    if (chk_pass !== 5'b11100 || chk_fail !== 5'b00000) begin
      n_errors++; $display("FAIL xnor_pass: got pass=%b fail=%b expected 11100 00000", chk_pass, chk_fail);
    end
    n_checks++;
    if (err_sticky !== 5'b00100) begin
      n_errors++; $display("FAIL b2b_sticky: got %b expected 00100", err_sticky);
    end
  endtask

  task automatic test_enables();
    checker_enable = 5'h1F; opcode_valid = 1'b1; opcode = 1'b0; data = 8'h81;
    tick();
    checker_enable = 5'h00;
    tick();
    n_checks++;
    if (chk_pass !== 5'b00000) begin
      n_errors++; $display("FAIL c2_live_disable: got %b expected 00000", chk_pass);
    end
    opcode_valid = 1'b0; data = 8'h00;
    done = 1'b1; result = 8'h02; overflow = 1'b1;
    tick();
    done = 1'b0; result = 8'h00; overflow = 1'b0;
    n_checks++;
    if (chk_pass !== 5'b11100) begin
      n_errors++; $display("FAIL snapshot_enabled: got %b expected 11100", chk_pass);
    end
    opcode_valid = 1'b1; data = 8'h01;
    tick();
    tick();
    opcode_valid = 1'b0; data = 8'h00; checker_enable = 5'h1F;
    done = 1'b1; result = 8'hAA; overflow = 1'b1;
    tick();
    done = 1'b0; result = 8'h00; overflow = 1'b0;
    n_checks++;
    if (chk_pass !== 5'b00000 || chk_fail !== 5'b00000) begin
      n_errors++; $display("FAIL snapshot_disabled: got pass=%b fail=%b expected 0 0", chk_pass, chk_fail);
    end
  endtask

  task automatic test_xz();
    logic probe;
    logic four_state;
    do_reset();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (chk_fail !== 5'b00100) begin
      n_errors++; $display("FAIL spurious_done_idle: got %b expected 00100", chk_fail);
    end
    probe = 1'bx;
    four_state = $isunknown(probe);
    opcode_valid = 1'b1; opcode = 1'bx; data = 8'hxx;
    tick();
    opcode_valid = 1'b0; opcode = 1'b0; data = 8'h00;
    n_checks++;
    if (chk_fail[1] !== four_state || chk_pass[1] !== !four_state) begin
      n_errors++; $display("FAIL c2_xz_operand: got pass1=%b fail1=%b expected fail1=%b", chk_pass[1], chk_fail[1], four_state);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 7; k++) run_op(8'h01, 1'b0, 8'h01, 1'b0, 1, 8'h00, 1'b1);
    n_checks++;
    if (fail_cnt !== 4'd14) begin
      n_errors++; $display("FAIL fail_cnt_pre_sat: got %0d expected 14", fail_cnt);
    end
    run_op(8'h01, 1'b0, 8'h01, 1'b0, 1, 8'h00, 1'b1);
    n_checks++;
    if (chk_fail !== 5'b11000 || fail_cnt !== 4'd15) begin
      n_errors++; $display("FAIL fail_cnt_saturate: got fail=%b cnt=%0d expected 11000 15", chk_fail, fail_cnt);
    end
    run_op(8'h01, 1'b0, 8'h01, 1'b0, 1, 8'h00, 1'b1);
    n_checks++;
    if (fail_cnt !== 4'd15 || pass_cnt !== 4'd15) begin
      n_errors++; $display("FAIL cnt_no_wrap: got fail_cnt=%0d pass_cnt=%0d expected 15 15", fail_cnt, pass_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_reset_fail();
    test_add();
    test_sub();
    test_timeout();
    test_back_to_back();
    test_enables();
    test_xz();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
